// File: rtl/fwrisc_div_pkg.sv
// Shared definitions for the iterative divider: RV32M divide opcodes
// and the controller state encoding.
package fwrisc_div_pkg;

  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_DIVU = 4'h5;
  localparam logic [3:0] OP_REM  = 4'h6;
  localparam logic [3:0] OP_REMU = 4'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } div_state_e;

endpackage

// File: rtl/fwrisc_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
// Kept as its own block so a multi-bit-per-cycle variant can chain several.
module fwrisc_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i[WIDTH-1:0], dvd_msb_i};
  assign diff    = shifted - {1'b0, dvs_i};
  // rem_i[WIDTH] is the bit shifted out of the window; when set, the true
  // shifted value exceeds any WIDTH-bit divisor, so it forces a subtract.
  assign q_bit_o = rem_i[WIDTH] | (shifted >= {1'b0, dvs_i});
  assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/fwrisc_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes, one quotient bit per cycle, then a sign
// fixup cycle. The dividend register doubles as the quotient register:
// each CALC cycle shifts a dividend bit out and a quotient bit in.
// Optional build macro FWRISC_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip CALC and load their known results directly (same results,
// shorter latency).
//
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | one quotient bit per cycle, WIDTH cycles
//   FIXUP | apply result sign, drive out and out_valid
module fwrisc_div_iter
  import fwrisc_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             is_signed;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_d;
  logic             q_bit_d;
  logic             is_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Request decode; |0x80000000| stays 0x80000000, read as unsigned.
  assign is_signed = (op == OP_DIV) || (op == OP_REM);
  assign b_zero    = (in_b == '0);
  assign a_mag     = (is_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag     = (is_signed && in_b[WIDTH-1]) ? -in_b : in_b;

`ifdef FWRISC_DIV_EARLY_OUT_EN
  logic sgn_ovf;
  assign sgn_ovf = is_signed && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
`endif

  assign in_ready = (state_q == IDLE);

  // Sign fixup of the magnitude results; unknown ops fall into DIVU.
  assign is_rem  = (op_q == OP_REM) || (op_q == OP_REMU);
  assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  fwrisc_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  // Controller and datapath registers, including the registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= is_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]) && !b_zero;
            neg_rem_q <= is_signed && in_a[WIDTH-1];
`ifdef FWRISC_DIV_EARLY_OUT_EN
            if (b_zero || sgn_ovf) begin
              // Preload what CALC would have produced for these cases.
              dvd_q   <= b_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
              rem_q   <= b_zero ? {1'b0, a_mag} : '0;
              state_q <= FIXUP;
            end else begin
              state_q <= CALC;
            end
`else
            state_q   <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          out       <= is_rem ? rem_fix : quo_fix;
          out_valid <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fwrisc_div_iter.md
Name: fwrisc_div_iter

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It is the inverse-operation companion to the single-cycle multiplier.
- Sits beside the multiplier in the mul/div/shift execute path. It uses the same in_a/in_b/op/in_valid to out/out_valid interface, plus a ready flag, because it is multi-cycle.
- Produces one quotient bit per cycle and applies a sign-fixup cycle at the end.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the parameter is used to derive counter and register widths.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, acts immediately, released synchronously to clock.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- op  in  4  operation: OP_DIV=4'h4, OP_DIVU=4'h5, OP_REM=4'h6, OP_REMU=4'h7.
- in_valid  in  1  request strobe; sampled only when in_ready=1.
- in_ready  out  1  1 when IDLE; request accepted on clock edge with in_valid&&in_ready.
- out  out  WIDTH  result, held until next acceptance.
- out_valid  out  1  single-cycle pulse marking out valid.

Behaviour:
- Reset (reset=0): state=IDLE, in_ready=1, out=0, out_valid=0, counter=0, internal regs=0. Reset mid-operation aborts the operation with no out_valid.
- States:
  - IDLE -> CALC on acceptance.
  - CALC -> FIXUP when counter reaches WIDTH-1.
  - FIXUP -> IDLE.
- Acceptance (edge E):
  - Latch op.
  - Signed ops (DIV/REM): latch |in_a| and |in_b|, neg_q = sign(a)^sign(b) && b!=0, neg_r = sign(a). Negation is two's complement, so |0x80000000| = 0x80000000, unsigned.
  - Unsigned ops: latch operands as-is.
  - Clear remainder reg (WIDTH+1 bits) and counter.
- CALC, each cycle:
  - rem = {rem[WIDTH-1:0], dvd[WIDTH-1]}; dvd <<= 1.
  - If rem >= dvs: rem -= dvs, shift 1 into the quotient, else shift 0.
  - counter++.
- FIXUP:
  - out = DIV/DIVU: (neg_q ? -q : q); REM/REMU: (neg_r ? -r : r).
  - out_valid=1 for this one edge; state returns to IDLE.
- Latency: out_valid asserted on edge E+WIDTH+1 (33 edges after acceptance for WIDTH=32). in_ready=0 from E through E+WIDTH+1; a new request can be accepted on E+WIDTH+2.
- in_valid while in_ready=0 is ignored; no queuing.
- Divide by zero falls out of the algorithm, as required by RISC-V:
  - quotient = 0xFFFFFFFF for both DIV and DIVU (neg_q forced 0);
  - remainder = dividend (sign restored).
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This must hold via the magnitude path; no special-casing is required without the optional feature.
- op values outside 4..7: accepted, treated as DIVU, result unspecified but out_valid still pulses.
- out is unchanged except on the FIXUP edge and reset.

Optional Feature:
- Macro: FWRISC_DIV_EARLY_OUT_EN.
- Defined:
  - At acceptance, divisor==0 or signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) skips CALC and goes to FIXUP with preloaded q/r.
  - Preloaded values: q=0xFFFFFFFF, r=a for div-by-zero; q=0x80000000, r=0 for overflow.
  - out_valid is asserted on E+1.
- Undefined: every op takes the full E+WIDTH+1 latency. Results are identical in both builds.

Decomposition:
- Package fwrisc_div_pkg: the op constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and the state typedef (IDLE, CALC, FIXUP).
- One natural sub-module, fwrisc_div_step: combinational single iteration. Inputs are rem, dvd MSB and dvs; outputs are next rem and quotient bit. It keeps the CALC datapath isolated for a later 2-bits/cycle variant.

Test Plan:
- DIVU a=100, b=7 -> out=14, out_valid exactly on 33rd edge after acceptance, in_ready low throughout; REMU same operands -> out=2.
- DIV a=0xFFFFFF9C(-100), b=7 -> 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); REM a=100, b=0xFFFFFFF9 -> 2.
- Div by zero: DIVU a=5, b=0 -> 0xFFFFFFFF; DIV a=-5, b=0 -> 0xFFFFFFFF; REM a=-5, b=0 -> 0xFFFFFFFB. Latency is 1 edge with FWRISC_DIV_EARLY_OUT_EN, 33 without.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Busy handling: in_valid held high continuously with changing operands -> only the first request and the request at E+34 are accepted; outputs match those two requests only.
- Reset mid-CALC: assert reset=0 at cycle 10 -> out=0, out_valid=0, in_ready=1 immediately (asynchronous); next request completes normally.
